// File: rtl/clk_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl_pkg
// Description : Shared state type and state encodings for the runtime
//               programmable clock-enable divider controller.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_ctrl_pkg;

    // Controller state. Kept as a plain 2-bit vector with named encodings
    // so that older tools and netlist consumers see fixed state values.
    typedef logic [1:0] state_t;

    localparam state_t S_STOPPED = 2'd0;  // idle, counter parked at 0
    localparam state_t S_RUN     = 2'd1;  // counting, ratio changes accepted
    localparam state_t S_PEND    = 2'd2;  // new ratio held until boundary
    localparam state_t S_DRAIN   = 2'd3;  // stop requested, finishing period

endpackage : clk_div_ctrl_pkg
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Runtime-programmable clock-enable divider. Produces a divided
//               level (clk_o) and a period-start strobe (tick_o). Ratio
//               changes, starts and stops only take effect on whole-period
//               boundaries so no runt or stretched periods are produced.
// Ports       : clk_i        - system clock
//               rst_i        - synchronous active-high reset
//               run_i        - 1 = run, 0 = stop at end of current period
//               div_i        - requested divide ratio
//               div_valid_i  - div_i valid
//               div_ready_o  - div_i can be accepted this cycle
//               div_err_o    - one-cycle pulse: accepted div_i was zero
//               clk_o        - divided level (pins/LEDs only)
//               tick_o       - high on the first cycle of each period
//               running_o    - controller is not stopped
//               div_active_o - ratio currently in effect
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int          CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    output logic             div_err_o,
    output logic             clk_o,
    output logic             tick_o,
    output logic             running_o,
    output logic [CNT_W-1:0] div_active_o
);

    localparam logic [CNT_W-1:0] C_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             err_q, err_d;

    logic             w_running;
    logic             w_boundary;
    logic             w_accept;
    logic             w_acc_ok;
    logic [CNT_W-1:0] w_cnt_next;

    // div_q is never zero (zero ratios are rejected), so div_q-1 cannot wrap.
    assign w_running  = (state_q != S_STOPPED);
    assign w_boundary = w_running && (cnt_q == (div_q - C_ONE));
    assign w_cnt_next = w_boundary ? '0 : (cnt_q + C_ONE);

    assign div_ready_o = (state_q == S_STOPPED) || ((state_q == S_RUN) && run_i);
    assign w_accept    = div_valid_i && div_ready_o;
    assign w_acc_ok    = w_accept && (div_i != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        div_pend_d = div_pend_q;
        err_d      = w_accept && (div_i == '0);

        case (state_q)
            S_STOPPED: begin
                cnt_d = '0;
                if (w_acc_ok) begin
                    div_d = div_i;
                end
                if (run_i) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                cnt_d = w_cnt_next;
                if (!run_i) begin
                    // ready is low here, so no ratio can be accepted as well
                    state_d = S_DRAIN;
                end else if (w_acc_ok) begin
                    if (w_boundary) begin
                        // New period starts straight away with the new ratio
                        div_d = div_i;
                        cnt_d = '0;
                    end else begin
                        div_pend_d = div_i;
                        state_d    = S_PEND;
                    end
                end
            end

            S_PEND: begin
                cnt_d = w_cnt_next;
                if (w_boundary) begin
                    div_d   = div_pend_q;
                    state_d = run_i ? S_RUN : S_STOPPED;
                end
            end

            S_DRAIN: begin
                cnt_d = w_cnt_next;
                if (run_i) begin
                    // Resume without disturbing the period in progress
                    state_d = S_RUN;
                end else if (w_boundary) begin
                    state_d = S_STOPPED;
                end
            end

            default: begin
                state_d = S_STOPPED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_STOPPED;
            cnt_q      <= '0;
            div_q      <= C_DEFAULT_DIV;
            div_pend_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            div_pend_q <= div_pend_d;
            err_q      <= err_d;
        end
    end

    // High for the first floor(div/2) cycles of each period
    assign clk_o        = w_running && (cnt_q < (div_q >> 1));
    assign tick_o       = w_running && (cnt_q == '0);
    assign running_o    = w_running;
    assign div_err_o    = err_q;
    assign div_active_o = div_q;

endmodule : clk_div_ctrl
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_ctrl
// Description : Self-checking bench for clk_div_ctrl: directed vector table,
//               hand-written stop/resume/reset sequences and randomized
//               stimulus checked every cycle against a period-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

    localparam int CNT_W = 16;
    localparam int DEF   = 4;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             run_i = 1'b0;
    logic [CNT_W-1:0] div_i = '0;
    logic             div_valid_i = 1'b0;
    logic             div_ready_o, div_err_o, clk_o, tick_o, running_o;
    logic [CNT_W-1:0] div_active_o;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .run_i       (run_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .div_err_o   (div_err_o),
        .clk_o       (clk_o),
        .tick_o      (tick_o),
        .running_o   (running_o),
        .div_active_o(div_active_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks where we are inside the current period,
    // the ratio in force, any held ratio and whether a stop is pending.
    // ------------------------------------------------------------------
    bit m_en = 0;
    bit m_run, m_pend_v, m_stop, m_err;
    int m_ph, m_ratio, m_pend;

    function automatic bit m_ready();
        return !m_run || (!m_pend_v && !m_stop && run_i);
    endfunction

    always @(posedge clk) begin
        bit acc, endp;
        int nxt;
        if (rst_i) begin
            m_run = 0; m_pend_v = 0; m_stop = 0; m_err = 0;
            m_ph = 0; m_ratio = DEF; m_pend = 0;
        end else begin
            acc   = div_valid_i && m_ready();
            endp  = m_run && (m_ph == m_ratio - 1);
            nxt   = endp ? 0 : m_ph + 1;
            m_err = acc && (div_i == 0);
            if (!m_run) begin
                if (acc && div_i != 0) m_ratio = int'(div_i);
                if (run_i) begin m_run = 1; m_ph = 0; end
            end else if (m_pend_v) begin
                m_ph = nxt;
                if (endp) begin
                    m_ratio = m_pend; m_pend_v = 0; m_run = run_i;
                end
            end else if (m_stop) begin
                m_ph = nxt;
                if (run_i) m_stop = 0;
                else if (endp) begin m_run = 0; m_stop = 0; m_ph = 0; end
            end else begin
                m_ph = nxt;
                if (!run_i) m_stop = 1;
                else if (acc && div_i != 0) begin
                    if (endp) begin m_ratio = int'(div_i); m_ph = 0; end
                    else begin m_pend_v = 1; m_pend = int'(div_i); end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [5+CNT_W-1:0] got, exp;
        if (m_en) begin
            got = {clk_o, tick_o, running_o, div_ready_o, div_err_o, div_active_o};
            exp = {m_run && (m_ph < m_ratio / 2), m_run && (m_ph == 0), m_run,
                   m_ready(), m_err, CNT_W'(m_ratio)};
            n_chk++;
            if (got === exp) n_pass++;
            else $display("FAIL model t=%0t {clk,tick,run,rdy,err,act}: got %h expected %h",
                          $time, got, exp);
        end
    end

    // Drive inputs, let one active edge pass, return just after it.
    task automatic cyc(input bit r, input bit rn, input int d, input bit v);
        rst_i = r; run_i = rn; div_i = CNT_W'(d); div_valid_i = v;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit run; int div; bit valid;
        bit e_clk, e_tick, e_run, e_rdy, e_err; int e_act;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(bit rn, int d, bit v, bit c, bit t, bit r,
                                bit rd, bit e, int a);
        vec_t x;
        x.run = rn; x.div = d; x.valid = v;
        x.e_clk = c; x.e_tick = t; x.e_run = r; x.e_rdy = rd; x.e_err = e; x.e_act = a;
        return x;
    endfunction

    initial begin
        int ticks;
        // run, div, valid | clk, tick, running, ready, err, active
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 4);  // stopped, run sampled
        tbl[1]  = mk(1, 0, 0, 1, 1, 1, 1, 0, 4);  // cnt0
        tbl[2]  = mk(1, 3, 1, 1, 0, 1, 1, 0, 4);  // cnt1: request 3 -> PEND
        tbl[3]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 4);  // cnt2 PEND
        tbl[4]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 4);  // cnt3 PEND boundary
        tbl[5]  = mk(1, 0, 0, 1, 1, 1, 1, 0, 3);  // div3 cnt0
        tbl[6]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 3);  // cnt1
        tbl[7]  = mk(1, 4, 1, 0, 0, 1, 1, 0, 3);  // cnt2 boundary: load 4
        tbl[8]  = mk(1, 0, 0, 1, 1, 1, 1, 0, 4);
        tbl[9]  = mk(1, 0, 0, 1, 0, 1, 1, 0, 4);
        tbl[10] = mk(1, 0, 0, 0, 0, 1, 1, 0, 4);
        tbl[11] = mk(1, 2, 1, 0, 0, 1, 1, 0, 4);  // cnt3 boundary: load 2
        tbl[12] = mk(1, 0, 0, 1, 1, 1, 1, 0, 2);
        tbl[13] = mk(1, 0, 0, 0, 0, 1, 1, 0, 2);
        tbl[14] = mk(0, 0, 0, 1, 1, 1, 0, 0, 2);  // drop run at cnt0
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 0, 2);  // DRAIN boundary
        tbl[16] = mk(0, 0, 1, 0, 0, 0, 1, 0, 2);  // stopped, zero ratio
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 1, 1, 2);  // error pulse
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 1, 0, 2);

        // Reset state
        cyc(1, 0, 0, 0);
        m_en = 1;
        cyc(1, 0, 0, 0);
        rst_i = 0;
        #1;
        chk("rst_clk", clk_o, 0);
        chk("rst_tick", tick_o, 0);
        chk("rst_running", running_o, 0);
        chk("rst_err", div_err_o, 0);
        chk("rst_ready", div_ready_o, 1);
        chk("rst_active", div_active_o, DEF);

        foreach (tbl[i]) begin
            run_i = tbl[i].run; div_i = CNT_W'(tbl[i].div); div_valid_i = tbl[i].valid;
            @(negedge clk);
            chk($sformatf("vec%0d_clk", i), clk_o, tbl[i].e_clk);
            chk($sformatf("vec%0d_tick", i), tick_o, tbl[i].e_tick);
            chk($sformatf("vec%0d_running", i), running_o, tbl[i].e_run);
            chk($sformatf("vec%0d_ready", i), div_ready_o, tbl[i].e_rdy);
            chk($sformatf("vec%0d_err", i), div_err_o, tbl[i].e_err);
            chk($sformatf("vec%0d_active", i), div_active_o, tbl[i].e_act);
            @(posedge clk); #1;
        end

        // Zero ratio in STOPPED with default ratio in force
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("zero_err_pulse", div_err_o, 1);
        chk("zero_active", div_active_o, DEF);
        cyc(0, 0, 0, 0);
        chk("zero_err_clear", div_err_o, 0);

        // Stop mid-period completes the period
        cyc(0, 1, 0, 0);  chk("stop_tick0", tick_o, 1);
        cyc(0, 1, 0, 0);  chk("stop_cnt1_clk", clk_o, 1);
        cyc(0, 0, 0, 0);  chk("stop_cnt2_running", running_o, 1);
        cyc(0, 0, 0, 0);  chk("stop_cnt3_running", running_o, 1);
        cyc(0, 0, 0, 0);  chk("stop_done_running", running_o, 0);
        chk("stop_done_clk", clk_o, 0);
        chk("stop_done_tick", tick_o, 0);

        // Stop then resume inside the same period: ticks keep cadence
        cyc(0, 1, 0, 0);  chk("resume_tick0", tick_o, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);  chk("resume_cnt3_running", running_o, 1);
        chk("resume_cnt3_tick", tick_o, 0);
        cyc(0, 1, 0, 0);  chk("resume_next_tick", tick_o, 1);

        // Reset while a ratio is pending discards it
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 7, 1);
        chk("pend_ready", div_ready_o, 0);
        chk("pend_active", div_active_o, DEF);
        cyc(1, 1, 0, 0);
        chk("prst_running", running_o, 0);
        chk("prst_clk", clk_o, 0);
        chk("prst_tick", tick_o, 0);
        chk("prst_active", div_active_o, DEF);
        ticks = 0;
        for (int k = 0; k < 9; k++) begin
            cyc(0, 1, 0, 0);
            ticks += int'(tick_o);
        end
        chk("prst_ticks_9cyc", ticks, 3);
        chk("prst_active_after", div_active_o, DEF);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
                int'($urandom_range(0, 6)), $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_clk_div_ctrl
`default_nettype wire
